// File: rtl/nand_alu_arbiter.sv
// -----------------------------------------------------------------------------
// nand_alu_arbiter
//   Round-robin arbiter and sequencer sharing one NAND-only logic unit among
//   NUM_REQ requesters. A granted requester's opcode and operands are captured
//   in IDLE. The operation runs in EXEC. The result is returned with a
//   one-cycle done pulse in DONE.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   inReq      per-requester request, level-held
//   inOp       per-requester 2-bit opcode, requester i at [2i+1:2i]
//   inA, inB   per-requester WIDTH-bit operands, packed like inOp
//   outGrant   one-hot grant, high during EXEC
//   outDone    one-hot done pulse, high during DONE
//   outResult  last result, held until the next DONE
//   outErr     pulses with outDone for the reserved opcode
//   outBusy    high whenever the FSM is not in IDLE
//
// Configuration
//   NAND_ALU_ARBITER_XOR_EN  defined: opcode 11 is XOR (four NANDs per bit)
//                            and outErr never asserts.
//                            undefined: opcode 11 returns 0 and pulses outErr.
// -----------------------------------------------------------------------------
module nand_alu_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         inReq,
   input  logic [2*NUM_REQ-1:0]       inOp,
   input  logic [WIDTH*NUM_REQ-1:0]   inA,
   input  logic [WIDTH*NUM_REQ-1:0]   inB,
   output logic [NUM_REQ-1:0]         outGrant,
   output logic [NUM_REQ-1:0]         outDone,
   output logic [WIDTH-1:0]           outResult,
   output logic                       outErr,
   output logic                       outBusy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_NOT = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   // (base + off) mod NUM_REQ, used for the round-robin search and ptr update
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned      off);
      return IDX_W'((32'(base) + off) % NUM_REQ);
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e               state_q,  state_d;
   logic [IDX_W-1:0]     ptr_q,    ptr_d;
   logic [IDX_W-1:0]     idx_q,    idx_d;
   logic [1:0]           op_q,     op_d;
   logic [WIDTH-1:0]     a_q,      a_d;
   logic [WIDTH-1:0]     b_q,      b_d;
   logic [NUM_REQ-1:0]   grant_q,  grant_d;
   logic [NUM_REQ-1:0]   done_q,   done_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 err_q,    err_d;
   logic                 busy_q,   busy_d;

   // ---------------------------------------------------------------------------
   // Split the packed request buses into per-requester entries
   // ---------------------------------------------------------------------------
   logic [1:0]       op_arr [NUM_REQ];
   logic [WIDTH-1:0] a_arr  [NUM_REQ];
   logic [WIDTH-1:0] b_arr  [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
      assign op_arr[g] = inOp[2*g +: 2];
      assign a_arr[g]  = inA[WIDTH*g +: WIDTH];
      assign b_arr[g]  = inB[WIDTH*g +: WIDTH];
   end

   // ---------------------------------------------------------------------------
   // NAND-only datapath on the captured operands
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] nand_ab_c;
   logic [WIDTH-1:0] and_c;
   logic [WIDTH-1:0] not_a_c;
   logic [WIDTH-1:0] not_b_c;
   logic [WIDTH-1:0] or_c;
   logic [WIDTH-1:0] alu_res_c;
   logic             alu_err_c;

   assign nand_ab_c = ~(a_q & b_q);
   assign and_c     = ~(nand_ab_c & nand_ab_c);   // NAND with tied inputs inverts
   assign not_a_c   = ~(a_q & a_q);
   assign not_b_c   = ~(b_q & b_q);
   assign or_c      = ~(not_a_c & not_b_c);       // De Morgan: A|B = ~(~A & ~B)

`ifdef NAND_ALU_ARBITER_XOR_EN
   logic [WIDTH-1:0] xor_a_c;
   logic [WIDTH-1:0] xor_b_c;
   logic [WIDTH-1:0] xor_c;

   // Classic four-NAND XOR, sharing the first NAND with the AND path
   assign xor_a_c = ~(a_q & nand_ab_c);
   assign xor_b_c = ~(b_q & nand_ab_c);
   assign xor_c   = ~(xor_a_c & xor_b_c);
`endif

   // Opcode select
   always_comb begin
      alu_res_c = '0;
      alu_err_c = 1'b0;
      case (op_q)
         OP_AND:  alu_res_c = and_c;
         OP_OR:   alu_res_c = or_c;
         OP_NOT:  alu_res_c = not_a_c;
         OP_RSV: begin
`ifdef NAND_ALU_ARBITER_XOR_EN
            alu_res_c = xor_c;
`else
            alu_err_c = 1'b1;
`endif
         end
         default: alu_res_c = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Round-robin search: first requester at or after ptr, wrapping
   // ---------------------------------------------------------------------------
   logic             req_found_c;
   logic [IDX_W-1:0] req_sel_c;

   always_comb begin
      req_found_c = 1'b0;
      req_sel_c   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!req_found_c && inReq[wrap_add(ptr_q, k)]) begin
            req_found_c = 1'b1;
            req_sel_c   = wrap_add(ptr_q, k);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and registered-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      idx_d    = idx_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      grant_d  = '0;
      done_d   = '0;
      result_d = result_q;
      err_d    = 1'b0;
      busy_d   = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (req_found_c) begin
               state_d = ST_EXEC;
               idx_d   = req_sel_c;
               op_d    = op_arr[req_sel_c];
               a_d     = a_arr[req_sel_c];
               b_d     = b_arr[req_sel_c];
               grant_d = NUM_REQ'(1) << req_sel_c;
               busy_d  = 1'b1;
            end
         end
         ST_EXEC: begin
            state_d  = ST_DONE;
            result_d = alu_res_c;
            err_d    = alu_err_c;
            done_d   = NUM_REQ'(1) << idx_q;
            busy_d   = 1'b1;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            ptr_d   = wrap_add(idx_q, 1);
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset discards any operation in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         idx_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         result_q <= result_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign outGrant  = grant_q;
   assign outDone   = done_q;
   assign outResult = result_q;
   assign outErr    = err_q;
   assign outBusy   = busy_q;

endmodule

// File: tb/tb_nand_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nand_alu_arbiter
//   Directed-vector bench for nand_alu_arbiter (NUM_REQ=4, WIDTH=4).
//   Inputs change and outputs are sampled on the falling edge.
//   Honours NAND_ALU_ARBITER_XOR_EN for the opcode-11 expectation.
// -----------------------------------------------------------------------------
module tb_nand_alu_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned WIDTH   = 4;
   localparam int unsigned IDX_W   = 2;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic [NUM_REQ-1:0]       inReq;
   logic [2*NUM_REQ-1:0]     inOp;
   logic [WIDTH*NUM_REQ-1:0] inA;
   logic [WIDTH*NUM_REQ-1:0] inB;
   logic [NUM_REQ-1:0]       outGrant;
   logic [NUM_REQ-1:0]       outDone;
   logic [WIDTH-1:0]         outResult;
   logic                     outErr;
   logic                     outBusy;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   nand_alu_arbiter #(
      .NUM_REQ (NUM_REQ),
      .WIDTH   (WIDTH),
      .IDX_W   (IDX_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .inReq     (inReq),
      .inOp      (inOp),
      .inA       (inA),
      .inB       (inB),
      .outGrant  (outGrant),
      .outDone   (outDone),
      .outResult (outResult),
      .outErr    (outErr),
      .outBusy   (outBusy)
   );

   always #5 clk = ~clk;

   // Single comparison point: count and report
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Load one requester's opcode and operands
   task automatic set_req(input int i, input logic [1:0] op,
                          input logic [3:0] a, input logic [3:0] b);
      inOp[2*i +: 2] = op;
      inA[4*i +: 4]  = a;
      inB[4*i +: 4]  = b;
   endtask

   // One full IDLE->EXEC->DONE->IDLE transaction, starting at a falling edge in
   // IDLE with requests already set. drop=1 clears inReq and scrambles all
   // operands right after capture; the result must be unaffected.
   task automatic run_one(input string tag, input int idx, input logic [3:0] res,
                          input logic err, input bit drop);
      @(posedge clk); @(negedge clk);
      if (drop) begin
         inReq = '0;
         inA   = ~inA;
         inB   = ~inB;
         inOp  = ~inOp;
      end
      check({tag, " exec grant"}, 32'(outGrant), 32'(1) << idx);
      check({tag, " exec busy"},  32'(outBusy),  32'(1));
      check({tag, " exec done"},  32'(outDone),  32'(0));
      @(posedge clk); @(negedge clk);
      check({tag, " done pulse"},  32'(outDone),   32'(1) << idx);
      check({tag, " done grant"},  32'(outGrant),  32'(0));
      check({tag, " done result"}, 32'(outResult), 32'(res));
      check({tag, " done err"},    32'(outErr),    32'(err));
      @(posedge clk); @(negedge clk);
      check({tag, " idle done"},   32'(outDone),   32'(0));
      check({tag, " idle busy"},   32'(outBusy),   32'(0));
      check({tag, " idle hold"},   32'(outResult), 32'(res));
   endtask

   initial begin
      reset_n = 1'b0;
      inReq   = '0;
      inOp    = '0;
      inA     = '0;
      inB     = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst grant",  32'(outGrant),  32'(0));
      check("rst done",   32'(outDone),   32'(0));
      check("rst result", 32'(outResult), 32'(0));
      check("rst err",    32'(outErr),    32'(0));
      check("rst busy",   32'(outBusy),   32'(0));
      reset_n = 1'b1;

      // Reset asserted mid-EXEC discards the operation
      inReq = 4'b0010;
      set_req(1, 2'b00, 4'b1100, 4'b1010);
      @(posedge clk); @(negedge clk);
      check("midrst pre grant", 32'(outGrant), 32'(4'b0010));
      reset_n = 1'b0;
      inReq   = '0;
      #1;
      check("midrst grant", 32'(outGrant), 32'(0));
      check("midrst busy",  32'(outBusy),  32'(0));
      check("midrst done",  32'(outDone),  32'(0));
      @(posedge clk); @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); @(negedge clk);
         check("midrst no done",   32'(outDone),   32'(0));
         check("midrst idle busy", 32'(outBusy),   32'(0));
         check("midrst result",    32'(outResult), 32'(0));
      end

      // All four requesting: rotation 0,1,2,3,0 (ptr is 0 after reset)
      inReq = 4'b1111;
      set_req(0, 2'b01, 4'b1100, 4'b1010);
      set_req(1, 2'b10, 4'b1100, 4'b1010);
      set_req(2, 2'b00, 4'b1100, 4'b1010);
      set_req(3, 2'b01, 4'b1100, 4'b1010);
      run_one("rr0",  0, 4'b1110, 1'b0, 1'b0);
      run_one("rr1",  1, 4'b0011, 1'b0, 1'b0);
      run_one("rr2",  2, 4'b1000, 1'b0, 1'b0);
      run_one("rr3",  3, 4'b1110, 1'b0, 1'b0);
      run_one("rr0b", 0, 4'b1110, 1'b0, 1'b0);
      inReq = '0;

      // Only req0, AND; search wraps from ptr=1 back to 0; operands scrambled
      inReq = 4'b0001;
      set_req(0, 2'b00, 4'b1100, 4'b1010);
      run_one("and0", 0, 4'b1000, 1'b0, 1'b1);

      // req2 pulsed for one IDLE cycle still completes (NOT, B ignored)
      inReq = 4'b0100;
      set_req(2, 2'b10, 4'b0110, 4'b1111);
      run_one("pulse2", 2, 4'b1001, 1'b0, 1'b1);

      // ptr is now 3: req3 wins over req0, then req0
      inReq = 4'b1001;
      set_req(0, 2'b01, 4'b0001, 4'b0010);
      set_req(3, 2'b00, 4'b1111, 4'b0101);
      run_one("ptr3", 3, 4'b0101, 1'b0, 1'b0);
      run_one("wrap0", 0, 4'b0011, 1'b0, 1'b0);
      inReq = '0;

      // Move ptr to 2 via a single req1
      inReq = 4'b0010;
      set_req(1, 2'b00, 4'b1111, 4'b1111);
      run_one("solo1", 1, 4'b1111, 1'b0, 1'b0);
      inReq = '0;

      // req1 and req3 with ptr=2: req3 first, then req1
      inReq = 4'b1010;
      set_req(1, 2'b10, 4'b0000, 4'b1010);
      set_req(3, 2'b01, 4'b1000, 4'b0001);
      run_one("skip3", 3, 4'b1001, 1'b0, 1'b0);
      run_one("skip1", 1, 4'b1111, 1'b0, 1'b0);
      inReq = '0;

      // Reserved / XOR opcode
      inReq = 4'b0001;
      set_req(0, 2'b11, 4'b0110, 4'b0101);
`ifdef NAND_ALU_ARBITER_XOR_EN
      run_one("op11", 0, 4'b0011, 1'b0, 1'b1);
`else
      run_one("op11", 0, 4'b0000, 1'b1, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
